event_frame_builder: RTL
========================

Name: event_frame_builder

Overview:
- Front-end stage that turns the raw DVS event stream (timestamp, x, y, polarity, valid) into a binary GRID x GRID occupancy frame.
- Its output feeds the logic-gate network input register.
- Events are binned into time windows. A window closes on a time span, an event-count cap or an external flush; each closed frame is published with a one-cycle valid strobe.

Parameters:
- GRID, 64, frame side length in pixels; INPUT_SIZE = GRID*GRID.
- COORD_SHIFT, 0, right-shift applied to x_coord/y_coord before binning (downscale of larger sensors).
- WINDOW_TICKS, 1000, window length in timestamp units.
- MAX_EVENTS, 2048, accepted-event cap per window; 0 disables the cap.
- POL_MODE, 0, polarity filter: 0 keeps both polarities, 1 keeps ON (polarity=1) only, 2 keeps OFF only.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- timestamp  in  34  event time, monotonic modulo 2^34
- x_coord  in  14  event column
- y_coord  in  14  event row
- polarity  in  1  event polarity
- is_valid  in  1  event qualifier, one event per cycle max
- flush  in  1  force-close the current window
- out_data  out  GRID*GRID  last published frame; bit index = y*GRID + x
- out_valid  out  1  one-cycle strobe marking a new out_data
- event_count  out  $clog2(MAX_EVENTS+1) (min 1)  accepted events in the current window
- dropped  out  16  saturating count of events rejected as out of range

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; frame, out_data, out_valid, event_count, dropped and window_start all 0. Reset mid-window discards the partial frame with no emission.
- Event acceptance: xs = x_coord >> COORD_SHIFT, ys = y_coord >> COORD_SHIFT.
  - xs >= GRID or ys >= GRID: event dropped, dropped increments (saturates at 16'hFFFF).
  - Event failing the POL_MODE filter: ignored silently.
  - Otherwise "accepted": frame[ys*GRID+xs] <= 1 (OR, idempotent). event_count increments on every accepted event, including duplicates.
- States:
  - IDLE: no open window. First accepted event sets the frame bit, latches window_start=timestamp, sets event_count=1 and goes to ACCUM. If MAX_EVENTS==1 it goes directly to EMIT instead.
  - ACCUM: each accepted event at timestamp t is checked with elapsed = (t - window_start) mod 2^34, in unsigned 34-bit arithmetic, so wrap-around is handled.
    - elapsed >= WINDOW_TICKS (time close): the current frame is published. The closing event is NOT in that frame; it opens the next window (frame = that bit only, window_start=t, event_count=1). State remains ACCUM.
    - Otherwise the event is accumulated. If event_count reaches MAX_EVENTS (count close), that event IS included, then go to EMIT.
  - EMIT: single-cycle state used for count close and flush close. out_valid asserted, frame cleared, event_count=0, then IDLE. An accepted event arriving in EMIT opens a new window as in IDLE, in the same cycle.
- Publish: out_data <= frame and out_valid=1 for exactly one cycle, the cycle after the closing event/flush is sampled (latency 1). out_data holds until the next publish.
- flush:
  - In ACCUM: the window closes, the event is excluded, then EMIT.
  - flush together with an accepted event in ACCUM: the current frame is published without the event, and the event opens a new window.
  - In IDLE or EMIT: flush is ignored; no empty frames are emitted.
- Dropped and filtered events never affect timing or window state.
- Back-to-back windows: out_valid may assert on consecutive cycles. There is no backpressure; the consumer must sample on out_valid.

Test Plan:
- Defaults. Events (x=3,y=2,t=10), (x=63,y=63,t=500), then (x=0,y=0,t=1010). Required: one cycle after the third event, out_valid=1 with out_data bits 131 and 4095 only. Bit 0 set in the new frame; event_count=1.
- Wrap-around. window_start at t=2^34-100, next event at t=950. elapsed=1050, so the window closes; an event at t=850 (elapsed 950) does not close it.
- MAX_EVENTS=4. Send 4 events to the same pixel (5,5) within the window. Required: out_valid one cycle after the 4th event, out_data has only bit 325, event_count=0, state=IDLE.
- Out-of-range and filter. With COORD_SHIFT=0, send x=64,y=0: dropped=1, no frame bit set. With POL_MODE=1, send a polarity=0 event: it is ignored and dropped is unchanged.
- Flush. Flush plus a simultaneous event (7,0) in ACCUM: the published frame lacks bit 7, and the next frame contains bit 7. Flush in IDLE: no out_valid.
- Reset mid-window. After 3 accepted events, assert reset asynchronously (no clock edge). Required: all outputs 0 immediately; after release, no stale frame is published.

Source files
------------

// File: rtl/event_frame_builder.sv
// DVS event binner: accumulates accepted events into a GRID x GRID occupancy frame
// and publishes it when the window closes on time span, event-count cap or flush.
module event_frame_builder #(
    parameter int GRID         = 64,
    parameter int COORD_SHIFT  = 0,
    parameter int WINDOW_TICKS = 1000,
    parameter int MAX_EVENTS   = 2048,
    parameter int POL_MODE     = 0,
    localparam int INPUT_SIZE  = GRID * GRID,
    localparam int CNT_W       = (MAX_EVENTS > 0) ? $clog2(MAX_EVENTS + 1) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [33:0]           timestamp,
    input  logic [13:0]           x_coord,
    input  logic [13:0]           y_coord,
    input  logic                  polarity,
    input  logic                  is_valid,
    input  logic                  flush,
    output logic [INPUT_SIZE-1:0] out_data,
    output logic                  out_valid,
    output logic [CNT_W-1:0]      event_count,
    output logic [15:0]           dropped
);

    localparam int IDX_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam logic [14:0]      GRID_L = 15'(GRID);
    localparam logic [IDX_W-1:0] GRID_I = IDX_W'(GRID);
    localparam logic [33:0]      WIN_T  = 34'(WINDOW_TICKS);
    localparam logic [CNT_W-1:0] CAP    = CNT_W'(MAX_EVENTS);

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

    // decoded view of the event presented this cycle
    typedef struct packed {
        logic             accept;
        logic             drop;
        logic [IDX_W-1:0] idx;
    } ev_t;

    state_t                state, state_n;
    logic [INPUT_SIZE-1:0] frame, frame_n, hit, pub_frame;
    logic [33:0]           window_start, start_n, elapsed;
    logic [CNT_W-1:0]      cnt_n, cnt_inc;
    logic [13:0]           xs, ys;
    logic                  in_range, pol_ok, time_close, cap_hit, pub;
    ev_t                   ev;

    assign xs       = x_coord >> COORD_SHIFT;
    assign ys       = y_coord >> COORD_SHIFT;
    assign in_range = ({1'b0, xs} < GRID_L) && ({1'b0, ys} < GRID_L);
    assign pol_ok   = (POL_MODE == 1) ? polarity :
                      (POL_MODE == 2) ? ~polarity : 1'b1;

    always_comb begin
        ev.accept = is_valid & in_range & pol_ok;
        ev.drop   = is_valid & ~in_range;
        ev.idx    = IDX_W'(ys) * GRID_I + IDX_W'(xs);
        hit       = '0;
        hit[ev.idx] = 1'b1;
    end

    // unsigned 34-bit difference makes timestamp wrap-around transparent
    assign elapsed    = timestamp - window_start;
    assign time_close = elapsed >= WIN_T;
    assign cnt_inc    = (&event_count) ? event_count : event_count + 1'b1;
    assign cap_hit    = (MAX_EVENTS != 0) && (cnt_inc == CAP);

    always_comb begin
        state_n   = state;
        frame_n   = frame;
        start_n   = window_start;
        cnt_n     = event_count;
        pub       = 1'b0;
        pub_frame = frame;
        case (state)
            IDLE, EMIT: begin
                state_n = IDLE;
                if (ev.accept) begin
                    start_n = timestamp;
                    if (MAX_EVENTS == 1) begin
                        pub       = 1'b1;
                        pub_frame = hit;
                        frame_n   = '0;
                        cnt_n     = '0;
                        state_n   = EMIT;
                    end else begin
                        frame_n = hit;
                        cnt_n   = CNT_W'(1);
                        state_n = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (flush || (ev.accept && time_close)) begin
                    // closing event is excluded and seeds the next window
                    pub = 1'b1;
                    if (ev.accept) begin
                        frame_n = hit;
                        start_n = timestamp;
                        cnt_n   = CNT_W'(1);
                    end else begin
                        frame_n = '0;
                        cnt_n   = '0;
                        state_n = EMIT;
                    end
                end else if (ev.accept) begin
                    frame_n = frame | hit;
                    cnt_n   = cnt_inc;
                    if (cap_hit) begin
                        pub       = 1'b1;
                        pub_frame = frame | hit;
                        frame_n   = '0;
                        cnt_n     = '0;
                        state_n   = EMIT;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            frame        <= '0;
            window_start <= '0;
            event_count  <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            dropped      <= '0;
        end else begin
            state        <= state_n;
            frame        <= frame_n;
            window_start <= start_n;
            event_count  <= cnt_n;
            out_valid    <= pub;
            if (pub) out_data <= pub_frame;
            if (ev.drop && dropped != 16'hFFFF) dropped <= dropped + 16'd1;
        end
    end

endmodule
